// File: rtl/mic_pkg.sv
// mic_pkg: shared CIC width, PCM code limits and PDM-to-signed helper for the mic-array front end.
package mic_pkg;

    function automatic int CIC_W(input int order, input int decim);
        return order * $clog2(decim) + 1;
    endfunction

    function automatic int pcm_max(input int bw);
        return 2 ** (bw - 1) - 1;
    endfunction

    function automatic int pcm_min(input int bw);
        return -(2 ** (bw - 1));
    endfunction

    function automatic logic signed [1:0] pdm_to_s(input logic b);
        return b ? 2'sb01 : 2'sb11;
    endfunction

endpackage

// File: rtl/cic_channel.sv
// cic_channel: one mic's CIC decimator -- pipelined integrators, comb chain, truncation with
// positive full-scale saturation.
module cic_channel
    import mic_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int ORDER     = 4,
    parameter int DECIM     = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 strobe_i,
    input  logic                 tick_i,
    input  logic                 load_i,
    input  logic                 pdm_i,
    output logic [BIT_WIDTH-1:0] pcm_o
);
    localparam int W  = CIC_W(ORDER, DECIM);
    // One guard bit so +2^(W-1) stays distinguishable from -2^(W-1).
    localparam int AW = W + 1;
    localparam logic signed [AW-1:0]  FULL = {2'b01, {(W - 1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0]  PMAX = BIT_WIDTH'(pcm_max(BIT_WIDTH));

    logic signed [AW-1:0] integ_q [ORDER];
    logic signed [AW-1:0] dly_q   [ORDER];
    logic signed [AW-1:0] comb_d  [ORDER+1];
    logic signed [AW-1:0] comb_q;
    logic [BIT_WIDTH-1:0] pcm_q, pcm_d;

    always_comb begin
        comb_d[0] = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++) comb_d[k+1] = comb_d[k] - dly_q[k];
        pcm_d = (comb_q == FULL) ? PMAX : comb_q[W-1 -: BIT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
                dly_q[k]   <= '0;
            end
            comb_q <= '0;
        end else begin
            if (strobe_i) begin
                integ_q[0] <= integ_q[0] + AW'(pdm_to_s(pdm_i));
                for (int k = 1; k < ORDER; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
            end
            if (tick_i) begin
                for (int k = 0; k < ORDER; k++) dly_q[k] <= comb_d[k];
                comb_q <= comb_d[ORDER];
            end
        end
        if (!rst_n) pcm_q <= '0;
        else if (load_i && !clr_i) pcm_q <= pcm_d;
    end

    assign pcm_o = pcm_q;
endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM clock generator, input synchroniser and NUM_MICS parallel CIC decimators
// with warm-up suppression and a single-cycle pcm_valid strobe.
module pdm_cic_decimator
    import mic_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_MICS  = 25,
    parameter int CLK_DIV   = 4,
    parameter int DECIM     = 64,
    parameter int ORDER     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [NUM_MICS-1:0]           pdm_data_in,
    output logic                          pdm_clk_out,
    output logic [NUM_MICS*BIT_WIDTH-1:0] pcm_data_out,
    output logic                          pcm_valid
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int NW = $clog2(DECIM);
    localparam int CW = $clog2(ORDER + 1);

    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [NW-1:0]       dec_cnt_q;
    logic [CW-1:0]       warm_cnt_q;
    logic [NUM_MICS-1:0] sync1_q, sync2_q;
    logic                pdm_clk_q, tick_q, load_q, valid_q;
    logic                clr, strobe, warm;

    always_comb begin
        clr       = !rst_n || !enable;
        div_cnt_d = (div_cnt_q == DW'(CLK_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
        strobe    = !clr && (div_cnt_q == DW'(CLK_DIV / 2 - 1));
        warm      = warm_cnt_q == CW'(ORDER);
    end

    // Comb runs the cycle after the decimating strobe, pcm loads one cycle later,
    // so pcm_valid lands 3 clk after that strobe. enable=0 keeps pcm_data_out.
    always_ff @(posedge clk) begin
        sync1_q <= pdm_data_in;
        sync2_q <= sync1_q;
        if (clr) begin
            div_cnt_q  <= '0;
            pdm_clk_q  <= 1'b0;
            dec_cnt_q  <= '0;
            warm_cnt_q <= '0;
            tick_q     <= 1'b0;
            load_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pdm_clk_q <= div_cnt_d < DW'(CLK_DIV / 2);
            if (strobe) dec_cnt_q <= dec_cnt_q + 1'b1;
            tick_q <= strobe && (dec_cnt_q == NW'(DECIM - 1));
            if (tick_q && !warm) warm_cnt_q <= warm_cnt_q + 1'b1;
            load_q  <= tick_q && warm;
            valid_q <= load_q;
        end
    end

    for (genvar m = 0; m < NUM_MICS; m++) begin : g_ch
        cic_channel #(
            .BIT_WIDTH(BIT_WIDTH),
            .ORDER    (ORDER),
            .DECIM    (DECIM)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (clr),
            .strobe_i(strobe),
            .tick_i  (tick_q),
            .load_i  (load_q),
            .pdm_i   (sync2_q[m]),
            .pcm_o   (pcm_data_out[m*BIT_WIDTH +: BIT_WIDTH])
        );
    end

    assign pdm_clk_out = pdm_clk_q;
    assign pcm_valid   = valid_q;
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: scenario table plus hand sequences; PCM words checked against a
// direct convolution with the ORDER-fold boxcar impulse response.
module tb_pdm_cic_decimator;
    localparam int BW  = 8;
    localparam int NM  = 25;
    localparam int CD  = 4;
    localparam int DEC = 64;
    localparam int ORD = 4;
    localparam int W   = ORD * $clog2(DEC) + 1;
    localparam int HL  = ORD * (DEC - 1) + 1;
    // Fixed latency from the decimating strobe to pcm_valid.
    localparam int LAT = 3;

    typedef logic [NM*BW-1:0] bus_t;
    typedef struct {
        int pat;
        bit use_rst;
        int n_valid;
        int tail;
        int e0;
        int e24;
    } scen_t;

    logic clk = 0, rst_n = 0, enable = 0;
    logic [NM-1:0] pdm_data_in = '0;
    logic pdm_clk_out, pcm_valid;
    bus_t pcm_data_out;

    int errors = 0, checks = 0;
    int h[HL];
    logic [NM-1:0] stim[1024];
    bus_t exp_bus = '0;
    scen_t tbl[5];

    always #5 clk = ~clk;

    pdm_cic_decimator #(
        .BIT_WIDTH(BW),
        .NUM_MICS (NM),
        .CLK_DIV  (CD),
        .DECIM    (DEC),
        .ORDER    (ORD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pdm_data_in (pdm_data_in),
        .pdm_clk_out (pdm_clk_out),
        .pcm_data_out(pcm_data_out),
        .pcm_valid   (pcm_valid)
    );

    task automatic chk(input string name, input bus_t act, input bus_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] model(input int k, input int m);
        int y, j;
        y = 0;
        for (int n = 0; n < HL; n++) begin
            j = DEC * (m + 1) - ORD - n;
            if (j >= 0) y += stim[j][k] ? h[n] : -h[n];
        end
        return (y >= 2 ** (W - 1)) ? BW'(2 ** (BW - 1) - 1) : BW'(y >>> (W - BW));
    endfunction

    task automatic run(input scen_t sc);
        int cyc, strobes, nval, expv, stop, budget, m;
        logic prev, vexp;
        for (int j = 0; j < 1024; j++)
            for (int k = 0; k < NM; k++) begin
                logic rnd;
                rnd = $urandom_range(99) < 32'(k * 4 + 2);
                stim[j][k] = sc.pat == 0 ? 1'b1 : sc.pat == 1 ? 1'b0 :
                             sc.pat == 2 ? (k == 0 ? (j % 2 == 0) : k == 24 ? 1'b1 : rnd) : rnd;
            end
        pdm_data_in = stim[0];
        if (sc.use_rst) begin
            rst_n   = 0;
            exp_bus = '0;
        end else enable = 0;
        repeat (10) begin
            @(negedge clk);
            chk("clear_pdm_clk", bus_t'(pdm_clk_out), bus_t'(1'b0));
            chk("clear_valid", bus_t'(pcm_valid), bus_t'(1'b0));
            chk("clear_hold", pcm_data_out, exp_bus);
        end
        rst_n   = 1;
        enable  = 1;
        cyc     = 0;
        strobes = 0;
        nval    = 0;
        expv    = -1;
        prev    = 0;
        budget  = CD * DEC * (sc.n_valid + ORD + 2) + 50;
        stop    = budget;
        while (cyc < stop) begin
            @(negedge clk);
            cyc++;
            vexp = (cyc == expv);
            if (vexp) begin
                nval++;
                m = strobes / DEC - 1;
                for (int k = 0; k < NM; k++) exp_bus[k*BW +: BW] = model(k, m);
                if (nval == 1) chk("first_valid_strobes", bus_t'(strobes), bus_t'((ORD + 1) * DEC));
                if (sc.e0 >= 0) chk("mic0_code", bus_t'(pcm_data_out[0 +: BW]), bus_t'(sc.e0));
                if (sc.e24 >= 0) chk("mic24_code", bus_t'(pcm_data_out[24*BW +: BW]), bus_t'(sc.e24));
                if (nval == sc.n_valid) stop = cyc + sc.tail;
            end
            chk("pcm_valid", bus_t'(pcm_valid), bus_t'(vexp));
            chk("pcm_data", pcm_data_out, exp_bus);
            if (prev && !pdm_clk_out) begin
                strobes++;
                if (strobes % DEC == 0 && strobes / DEC >= ORD + 1) expv = cyc - 1 + LAT;
                pdm_data_in = stim[strobes];
            end
            prev = pdm_clk_out;
        end
        chk("valid_count", bus_t'(nval), bus_t'(sc.n_valid));
    endtask

    initial begin
        int t[HL];
        h    = '{default: 0};
        h[0] = 1;
        repeat (ORD) begin
            for (int i = 0; i < HL; i++) begin
                t[i] = 0;
                for (int k = 0; k < DEC; k++) if (i >= k) t[i] += h[i-k];
            end
            h = t;
        end

        tbl[0] = '{0, 1'b1, 2, 0,   'h7F, 'h7F};
        tbl[1] = '{1, 1'b0, 2, 100, 'h80, 'h80};
        tbl[2] = '{2, 1'b0, 3, 37,  'h00, 'h7F};
        tbl[3] = '{3, 1'b1, 2, 50,  -1,   -1};
        tbl[4] = '{2, 1'b1, 2, 0,   'h00, 'h7F};

        rst_n  = 0;
        enable = 1;
        repeat (5) begin
            @(negedge clk);
            chk("rst_pdm_clk", bus_t'(pdm_clk_out), bus_t'(1'b0));
            chk("rst_valid", bus_t'(pcm_valid), bus_t'(1'b0));
            chk("rst_data", pcm_data_out, '0);
        end
        rst_n  = 1;
        enable = 0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_pdm_clk", bus_t'(pdm_clk_out), bus_t'(1'b0));
        end
        enable = 1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            chk("divider", bus_t'(pdm_clk_out), bus_t'(c % CD < CD / 2));
        end

        for (int i = 0; i < 5; i++) run(tbl[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
